// File: rtl/in_channel_pkg.sv
// Shared types and helpers for the input-channel producer block.
package in_channel_pkg;

  localparam int unsigned DefaultMemoryElementWidth = 12;

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    SEALED  = 2'd1,
    DRAINED = 2'd2
  } chanState_t;

  // Pointer increment with an explicit wrap, valid for any depth >= 1.
  function automatic int unsigned nextPtr(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/in_channel_store.sv
// Circular word store for the input channel: one write port, show-ahead read port,
// async reset to zero or to a supplied initial image.
module in_channel_store
  import in_channel_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int unsigned NIn = 3,
  parameter int unsigned PtrWidth = 2,
  parameter int unsigned InitCount = 0,
  parameter logic [NIn*MemoryElementWidth-1:0] InitWords = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wrEn,
  input  logic [PtrWidth-1:0]           wrPtr,
  input  logic [MemoryElementWidth-1:0] wrData,
  input  logic [PtrWidth-1:0]           rdPtr,
  output logic [MemoryElementWidth-1:0] rdData
);

  logic [MemoryElementWidth-1:0] mem [NIn];

  // Entries beyond InitCount come out of reset as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NIn); i++) begin
        mem[i] <= (i < int'(InitCount)) ?
                  InitWords[i*MemoryElementWidth +: MemoryElementWidth] : '0;
      end
    end else if (wrEn) begin
      mem[wrPtr] <= wrData;
    end
  end

  assign rdData = mem[rdPtr];

endmodule

// File: rtl/in_channel_writer.sv
// Producer side of the machine input channel: valid/ready intake, show-ahead pop port,
// sealed/drained tracking. Optional reset preload under `IN_CHANNEL_PRELOAD_EN.
module in_channel_writer
  import in_channel_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int unsigned NIn = 3,
  parameter int unsigned CountWidth = $clog2(NIn + 1)
`ifdef IN_CHANNEL_PRELOAD_EN
  ,
  parameter int unsigned PreloadCount = 3,
  parameter logic [NIn*MemoryElementWidth-1:0] PreloadWords = {12'd11, 12'd22, 12'd33}
`endif
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wrValid,
  input  logic [MemoryElementWidth-1:0] wrData,
  input  logic                          wrLast,
  output logic                          wrReady,
  input  logic                          rdPop,
  output logic [MemoryElementWidth-1:0] rdData,
  output logic                          rdValid,
  output logic [CountWidth-1:0]         inSize,
  output logic                          sealed,
  output logic                          drained,
  output logic                          underflow,
  output logic                          overflow
);

  localparam int unsigned PtrWidth = (NIn > 1) ? $clog2(NIn) : 1;

`ifdef IN_CHANNEL_PRELOAD_EN
  if (PreloadCount > NIn) begin : gBadPreload
    $error("in_channel_writer: PreloadCount exceeds NIn");
  end
  localparam int unsigned ResetCount = PreloadCount;
  localparam int unsigned ResetWrPtr = PreloadCount % NIn;
  localparam chanState_t  ResetState = (PreloadCount == NIn) ? SEALED : OPEN;
  localparam logic [NIn*MemoryElementWidth-1:0] InitWords = PreloadWords;
`else
  localparam int unsigned ResetCount = 0;
  localparam int unsigned ResetWrPtr = 0;
  localparam chanState_t  ResetState = OPEN;
  localparam logic [NIn*MemoryElementWidth-1:0] InitWords = '0;
`endif

  chanState_t              state, stateNext;
  logic [PtrWidth-1:0]     wrPtr, wrPtrNext, rdPtr, rdPtrNext;
  logic [CountWidth-1:0]   count, countNext;
  logic                    underflowNext, overflowNext;
  logic                    push, pop;
  logic [MemoryElementWidth-1:0] storeRdData;

  in_channel_store #(
    .MemoryElementWidth(MemoryElementWidth),
    .NIn               (NIn),
    .PtrWidth          (PtrWidth),
    .InitCount         (ResetCount),
    .InitWords         (InitWords)
  ) uStore (
    .clock (clock),
    .reset (reset),
    .wrEn  (push),
    .wrPtr (wrPtr),
    .wrData(wrData),
    .rdPtr (rdPtr),
    .rdData(storeRdData)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ResetState;
      wrPtr     <= PtrWidth'(ResetWrPtr);
      rdPtr     <= '0;
      count     <= CountWidth'(ResetCount);
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= stateNext;
      wrPtr     <= wrPtrNext;
      rdPtr     <= rdPtrNext;
      count     <= countNext;
      underflow <= underflowNext;
      overflow  <= overflowNext;
    end
  end

  // Handshake, pointer/count update and seal/drain sequencing.
  always_comb begin
    stateNext     = state;
    wrPtrNext     = wrPtr;
    rdPtrNext     = rdPtr;
    countNext     = count;
    underflowNext = underflow;
    overflowNext  = overflow;

    wrReady = (state == OPEN) && (count < CountWidth'(NIn));
    push    = wrValid && wrReady;
    pop     = rdPop && (count != '0);

    if (push) wrPtrNext = PtrWidth'(nextPtr(32'(wrPtr), NIn));
    if (pop)  rdPtrNext = PtrWidth'(nextPtr(32'(rdPtr), NIn));

    case ({push, pop})
      2'b10:   countNext = count + CountWidth'(1);
      2'b01:   countNext = count - CountWidth'(1);
      default: countNext = count;
    endcase

    if (rdPop && (count == '0)) underflowNext = 1'b1;
    if (wrValid && (state != OPEN)) overflowNext = 1'b1;

    case (state)
      OPEN:    if (push && wrLast) stateNext = SEALED;
      SEALED:  if (countNext == '0) stateNext = DRAINED;
      DRAINED: stateNext = DRAINED;
      default: stateNext = OPEN;
    endcase
  end

  // Head word reads zero whenever the channel is empty.
  assign rdValid = (count != '0);
  assign rdData  = rdValid ? storeRdData : '0;
  assign inSize  = count;
  assign sealed  = (state != OPEN);
  assign drained = (state == DRAINED);

endmodule
